// File: rtl/jvm_param_queue_pkg.sv
// Shared constants and types for the JVM parameter queue.
// Mode select codes must stay aligned with the ones state_machine drives.
package jvm_param_queue_pkg;

    typedef enum logic {
        Q_FETCH = 1'b0,
        Q_ITER  = 1'b1
    } q_sel_e;

    localparam int PQ_DEPTH  = 8;
    localparam int PQ_WORD_W = 16;
    localparam int PQ_CNT_W  = $clog2(PQ_DEPTH) + 1;

    typedef logic [PQ_WORD_W-1:0] pq_word_t;

    function automatic pq_word_t zext_byte(input logic [7:0] b);
        return {8'h00, b};
    endfunction

endpackage

// File: rtl/jvm_param_queue_if.sv
// Bundle between state_machine/emitter (master) and the parameter queue (slave).
// Handshake: no backpressure; a push while full is dropped and flagged (overflow), a pop while
// empty is ignored and flagged (underflow); param_valid qualifies param_out, which is show-ahead.
interface jvm_param_queue_if
    import jvm_param_queue_pkg::*;
#(
    parameter int CNT_W = PQ_CNT_W
);
    q_sel_e         q_select;
    logic           is_wide;
    logic           push_wide;
    logic           byte_valid;
    logic [7:0]     byte_in;
    logic           pop;
    logic           flush;
    pq_word_t       param_out;
    logic           param_valid;
    logic [CNT_W-1:0] count;
    logic           full;
    logic           overflow;
    logic           underflow;

    modport master (
        output q_select, is_wide, push_wide, byte_valid, byte_in, pop, flush,
        input  param_out, param_valid, count, full, overflow, underflow
    );

    modport slave (
        input  q_select, is_wide, push_wide, byte_valid, byte_in, pop, flush,
        output param_out, param_valid, count, full, overflow, underflow
    );

endinterface

// File: rtl/jvm_param_queue_pq_fifo_mem.sv
// Entry storage for the parameter queue: one write port, asynchronous read port.
module pq_fifo_mem #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // Contents need no reset: count gates every read that is ever observed.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/jvm_param_queue.sv
// Operand FIFO behind state_machine: pairs wide operand bytes into 16-bit entries while fetching,
// serves them in order to the ARM emitter while iterating.
module jvm_param_queue
    import jvm_param_queue_pkg::*;
#(
    parameter int DEPTH = PQ_DEPTH,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input logic              clk,
    input logic              reset,
    jvm_param_queue_if.slave pq
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pend_q, pend_d;
    logic [7:0]       hi_q, hi_d;
    logic             ovf_q, ovf_d;
    logic             udf_q, udf_d;
    q_sel_e           sel_q, sel_d;

    logic             mode_entry;
    logic [CNT_W-1:0] base_count;
    logic             base_pend;
    logic             push_req;
    logic             wr_en;
    pq_word_t         push_word;
    pq_word_t         rd_data;

    always_comb begin
        sel_d      = pq.q_select;
        mode_entry = (pq.q_select == Q_FETCH) && (sel_q == Q_ITER);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        pend_d     = pend_q;
        hi_d       = hi_q;
        ovf_d      = ovf_q;
        udf_d      = udf_q;
        base_count = count_q;
        base_pend  = pend_q;
        push_req   = 1'b0;
        push_word  = '0;
        wr_en      = 1'b0;

        if (pq.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            pend_d   = 1'b0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            // Re-entering FETCH abandons the previous instruction's leftovers, but the byte
            // arriving this cycle still lands in the now-empty queue.
            if (mode_entry) begin
                rd_ptr_d   = wr_ptr_q;
                base_count = '0;
                base_pend  = 1'b0;
            end
            count_d = base_count;
            pend_d  = base_pend;

            if (pq.q_select == Q_FETCH) begin
                if (pq.byte_valid) begin
                    if (!pq.is_wide) begin
                        push_req  = 1'b1;
                        push_word = zext_byte(pq.byte_in);
                    end else if (!base_pend) begin
                        hi_d   = pq.byte_in;
                        pend_d = 1'b1;
                    end else begin
                        push_req  = 1'b1;
                        push_word = {hi_q, pq.byte_in};
                        pend_d    = 1'b0;
                    end
                end else if (pq.push_wide && base_pend) begin
                    push_req  = 1'b1;
                    push_word = zext_byte(hi_q);
                    pend_d    = 1'b0;
                end

                if (push_req) begin
                    if (base_count == FULL_CNT) begin
                        ovf_d = 1'b1;
                    end else begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + PTR_W'(1);
                        count_d  = base_count + CNT_W'(1);
                    end
                end
            end else if (pq.pop) begin
                if (count_q == '0) begin
                    udf_d = 1'b1;
                end else begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    count_d  = count_q - CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            pend_q   <= 1'b0;
            hi_q     <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
            sel_q    <= Q_FETCH;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
            hi_q     <= hi_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
            sel_q    <= sel_d;
        end
    end

    pq_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (PQ_WORD_W)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (push_word),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data)
    );

    assign pq.param_out   = (count_q == '0) ? '0 : rd_data;
    assign pq.param_valid = (count_q != '0);
    assign pq.count       = count_q;
    assign pq.full        = (count_q == FULL_CNT);
    assign pq.overflow    = ovf_q;
    assign pq.underflow   = udf_q;

endmodule

// File: tb/tb_jvm_param_queue.sv
// Self-checking bench for jvm_param_queue: directed scenarios plus a randomized run against
// a queue-based reference model.
module tb_jvm_param_queue;
    import jvm_param_queue_pkg::*;

    localparam int DEPTH = PQ_DEPTH;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    jvm_param_queue_if pq_if ();

    jvm_param_queue dut (
        .clk   (clk),
        .reset (rst),
        .pq    (pq_if)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model
    logic [15:0] exp_q[$];
    logic        m_pend;
    logic [7:0]  m_hi;
    logic        m_ovf;
    logic        m_udf;
    q_sel_e      m_prev_sel;

    task automatic model_step();
        logic        has;
        logic [15:0] w;
        if (rst) begin
            exp_q.delete();
            m_pend = 1'b0; m_hi = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;
            m_prev_sel = Q_FETCH;
        end else begin
            if (pq_if.flush) begin
                exp_q.delete();
                m_pend = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
            end else begin
                if (pq_if.q_select == Q_FETCH && m_prev_sel == Q_ITER) begin
                    exp_q.delete();
                    m_pend = 1'b0;
                end
                if (pq_if.q_select == Q_FETCH) begin
                    has = 1'b0;
                    w   = 16'h0000;
                    if (pq_if.byte_valid) begin
                        if (!pq_if.is_wide) begin
                            has = 1'b1; w = {8'h00, pq_if.byte_in};
                        end else if (!m_pend) begin
                            m_hi = pq_if.byte_in; m_pend = 1'b1;
                        end else begin
                            has = 1'b1; w = {m_hi, pq_if.byte_in}; m_pend = 1'b0;
                        end
                    end else if (pq_if.push_wide && m_pend) begin
                        has = 1'b1; w = {8'h00, m_hi}; m_pend = 1'b0;
                    end
                    if (has) begin
                        if (exp_q.size() == DEPTH) m_ovf = 1'b1;
                        else exp_q.push_back(w);
                    end
                end else if (pq_if.pop) begin
                    if (exp_q.size() == 0) m_udf = 1'b1;
                    else void'(exp_q.pop_front());
                end
            end
            m_prev_sel = pq_if.q_select;
        end
    endtask

    // Driver: present one cycle of inputs, advance a clock, return strobes to idle
    task automatic step(input q_sel_e sel, input logic wide, input logic pw, input logic bv,
                        input logic [7:0] b, input logic p, input logic fl);
        pq_if.q_select   = sel;
        pq_if.is_wide    = wide;
        pq_if.push_wide  = pw;
        pq_if.byte_valid = bv;
        pq_if.byte_in    = b;
        pq_if.pop        = p;
        pq_if.flush      = fl;
        @(posedge clk);
        model_step();
        #1;
        pq_if.push_wide  = 1'b0;
        pq_if.byte_valid = 1'b0;
        pq_if.pop        = 1'b0;
        pq_if.flush      = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(Q_FETCH, 0, 0, 0, 8'h00, 0, 0);
        step(Q_FETCH, 0, 0, 0, 8'h00, 0, 0);
        rst = 1'b0;
        checks++; if (pq_if.param_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", pq_if.param_valid); end
        checks++; if (pq_if.count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", pq_if.count); end
        checks++; if (pq_if.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", pq_if.full); end
        checks++; if (pq_if.param_out !== 16'h0000) begin errors++; $display("FAIL reset_out: got %h want 0000", pq_if.param_out); end
        checks++; if ({pq_if.overflow, pq_if.underflow} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b want 00", {pq_if.overflow, pq_if.underflow}); end
    endtask

    task automatic test_narrow();
        step(Q_FETCH, 0, 0, 1, 8'h12, 0, 0);
        checks++; if (pq_if.param_out !== 16'h0012) begin errors++; $display("FAIL narrow_latency: got %h want 0012", pq_if.param_out); end
        step(Q_FETCH, 0, 0, 1, 8'h34, 0, 0);
        step(Q_ITER, 0, 0, 0, 8'h00, 0, 0);
        checks++; if (pq_if.param_out !== 16'h0012) begin errors++; $display("FAIL narrow_head0: got %h want 0012", pq_if.param_out); end
        checks++; if (pq_if.count !== 4'd2) begin errors++; $display("FAIL narrow_count: got %0d want 2", pq_if.count); end
        step(Q_ITER, 0, 0, 0, 8'h00, 1, 0);
        checks++; if (pq_if.param_out !== 16'h0034) begin errors++; $display("FAIL narrow_head1: got %h want 0034", pq_if.param_out); end
        step(Q_ITER, 0, 0, 0, 8'h00, 1, 0);
        checks++; if (pq_if.param_valid !== 1'b0) begin errors++; $display("FAIL narrow_empty: got %b want 0", pq_if.param_valid); end
        checks++; if (pq_if.underflow !== 1'b0) begin errors++; $display("FAIL narrow_no_udf: got %b want 0", pq_if.underflow); end
        step(Q_ITER, 0, 0, 0, 8'h00, 1, 0);
        checks++; if (pq_if.underflow !== 1'b1) begin errors++; $display("FAIL underflow_set: got %b want 1", pq_if.underflow); end
        checks++; if (pq_if.count !== 4'd0) begin errors++; $display("FAIL underflow_count: got %0d want 0", pq_if.count); end
    endtask

    task automatic test_wide();
        step(Q_FETCH, 0, 0, 0, 8'h00, 0, 1);
        checks++; if (pq_if.underflow !== 1'b0) begin errors++; $display("FAIL flush_clears_udf: got %b want 0", pq_if.underflow); end
        step(Q_FETCH, 1, 0, 1, 8'hAB, 0, 0);
        checks++; if (pq_if.count !== 4'd0) begin errors++; $display("FAIL wide_half: got %0d want 0", pq_if.count); end
        step(Q_FETCH, 1, 0, 1, 8'hCD, 0, 0);
        checks++; if (pq_if.count !== 4'd1) begin errors++; $display("FAIL wide_count: got %0d want 1", pq_if.count); end
        checks++; if (pq_if.param_out !== 16'hABCD) begin errors++; $display("FAIL wide_word: got %h want abcd", pq_if.param_out); end
    endtask

    task automatic test_odd_wide();
        step(Q_FETCH, 0, 0, 0, 8'h00, 0, 1);
        step(Q_FETCH, 1, 0, 1, 8'h7F, 0, 0);
        step(Q_FETCH, 1, 1, 0, 8'h00, 0, 0);
        checks++; if (pq_if.param_out !== 16'h007F) begin errors++; $display("FAIL odd_word: got %h want 007f", pq_if.param_out); end
        step(Q_FETCH, 1, 0, 1, 8'h33, 0, 0);
        step(Q_FETCH, 1, 0, 1, 8'h44, 0, 0);
        checks++; if (pq_if.count !== 4'd2) begin errors++; $display("FAIL odd_pend_cleared: got %0d want 2", pq_if.count); end
        step(Q_FETCH, 0, 0, 0, 8'h00, 1, 0);
        checks++; if (pq_if.count !== 4'd2) begin errors++; $display("FAIL pop_in_fetch: got %0d want 2", pq_if.count); end
        step(Q_FETCH, 0, 0, 0, 8'h00, 0, 1);
        step(Q_FETCH, 1, 0, 1, 8'h11, 0, 0);
        step(Q_FETCH, 1, 1, 1, 8'h22, 0, 0);
        checks++; if (pq_if.param_out !== 16'h1122) begin errors++; $display("FAIL wide_with_push_wide: got %h want 1122", pq_if.param_out); end
        checks++; if (pq_if.count !== 4'd1) begin errors++; $display("FAIL wide_with_push_wide_cnt: got %0d want 1", pq_if.count); end
    endtask

    task automatic test_full();
        step(Q_FETCH, 0, 0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 3; i++) step(Q_FETCH, 0, 0, 1, 8'hA0 + 8'(i), 0, 0);
        step(Q_ITER, 0, 0, 0, 8'h00, 0, 0);
        for (int i = 0; i < 3; i++) step(Q_ITER, 0, 0, 0, 8'h00, 1, 0);
        for (int i = 1; i <= 9; i++) step(Q_FETCH, 0, 0, 1, 8'(i), 0, 0);
        checks++; if (pq_if.count !== 4'd8) begin errors++; $display("FAIL full_count: got %0d want 8", pq_if.count); end
        checks++; if (pq_if.full !== 1'b1) begin errors++; $display("FAIL full_flag: got %b want 1", pq_if.full); end
        checks++; if (pq_if.overflow !== 1'b1) begin errors++; $display("FAIL overflow_set: got %b want 1", pq_if.overflow); end
        step(Q_ITER, 0, 0, 0, 8'h00, 0, 0);
        for (int i = 1; i <= 8; i++) begin
            checks++; if (pq_if.param_out !== 16'(i)) begin errors++; $display("FAIL full_order[%0d]: got %h want %h", i, pq_if.param_out, 16'(i)); end
            step(Q_ITER, 0, 0, 0, 8'h00, 1, 0);
        end
        checks++; if (pq_if.param_valid !== 1'b0) begin errors++; $display("FAIL full_drained: got %b want 0", pq_if.param_valid); end
    endtask

    task automatic test_mode_reentry();
        step(Q_FETCH, 0, 0, 0, 8'h00, 0, 1);
        for (int i = 0; i < 3; i++) step(Q_FETCH, 0, 0, 1, 8'h60 + 8'(i), 0, 0);
        step(Q_ITER, 0, 0, 0, 8'h00, 0, 0);
        step(Q_FETCH, 0, 0, 1, 8'h55, 0, 0);
        checks++; if (pq_if.count !== 4'd1) begin errors++; $display("FAIL reentry_count: got %0d want 1", pq_if.count); end
        checks++; if (pq_if.param_out !== 16'h0055) begin errors++; $display("FAIL reentry_head: got %h want 0055", pq_if.param_out); end
    endtask

    task automatic test_reset_mid_pair();
        step(Q_FETCH, 0, 0, 0, 8'h00, 0, 1);
        step(Q_ITER, 0, 0, 0, 8'h00, 1, 0);
        step(Q_FETCH, 1, 0, 1, 8'hEE, 0, 0);
        rst = 1'b1;
        step(Q_FETCH, 0, 0, 0, 8'h00, 0, 0);
        rst = 1'b0;
        checks++; if ({pq_if.overflow, pq_if.underflow} !== 2'b00) begin errors++; $display("FAIL midpair_flags: got %b want 00", {pq_if.overflow, pq_if.underflow}); end
        step(Q_FETCH, 0, 0, 1, 8'h01, 0, 0);
        checks++; if (pq_if.param_out !== 16'h0001) begin errors++; $display("FAIL midpair_head: got %h want 0001", pq_if.param_out); end
        step(Q_FETCH, 1, 0, 1, 8'h02, 0, 0);
        step(Q_FETCH, 1, 0, 1, 8'h03, 0, 0);
        checks++; if (pq_if.count !== 4'd2) begin errors++; $display("FAIL midpair_count: got %0d want 2", pq_if.count); end
    endtask

    task automatic test_random();
        q_sel_e      sel;
        logic        wide;
        logic [15:0] exp_head;
        rst = 1'b1;
        step(Q_FETCH, 0, 0, 0, 8'h00, 0, 0);
        rst = 1'b0;
        sel  = Q_FETCH;
        wide = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 5) == 0) sel = (sel == Q_FETCH) ? Q_ITER : Q_FETCH;
            if ($urandom_range(0, 3) == 0) wide = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 99) == 0);
            step(sel, wide, 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 9) < 6),
                 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 49) == 0));
            rst = 1'b0;
            exp_head = (exp_q.size() != 0) ? exp_q[0] : 16'h0000;
            checks++; if (pq_if.param_out !== exp_head) begin errors++; $display("FAIL rand_out @%0d: got %h want %h", n, pq_if.param_out, exp_head); end
            checks++; if (pq_if.count !== 4'(exp_q.size())) begin errors++; $display("FAIL rand_count @%0d: got %0d want %0d", n, pq_if.count, exp_q.size()); end
            checks++; if (pq_if.param_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL rand_valid @%0d: got %b", n, pq_if.param_valid); end
            checks++; if (pq_if.full !== (exp_q.size() == DEPTH)) begin errors++; $display("FAIL rand_full @%0d: got %b", n, pq_if.full); end
            checks++; if (pq_if.overflow !== m_ovf) begin errors++; $display("FAIL rand_ovf @%0d: got %b want %b", n, pq_if.overflow, m_ovf); end
            checks++; if (pq_if.underflow !== m_udf) begin errors++; $display("FAIL rand_udf @%0d: got %b want %b", n, pq_if.underflow, m_udf); end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst    = 1'b1;
        pq_if.q_select   = Q_FETCH;
        pq_if.is_wide    = 1'b0;
        pq_if.push_wide  = 1'b0;
        pq_if.byte_valid = 1'b0;
        pq_if.byte_in    = 8'h00;
        pq_if.pop        = 1'b0;
        pq_if.flush      = 1'b0;
        test_reset();
        test_narrow();
        test_wide();
        test_odd_wide();
        test_full();
        test_mode_reentry();
        test_reset_mid_pair();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
